// File: rtl/student_audio_router.sv
// Frame router between a multi-channel codec and one shared FIR engine.
// Each channel is muted, bypassed or sent through the FIR (optionally inverted), then the whole frame is emitted.
module student_audio_router #(
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 27,
  parameter int NUM_CH            = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                adc_valid_i,
  input  logic [NUM_CH*DATA_SIZE-1:0]         adc_data_i,
  input  logic [2*NUM_CH-1:0]                 mode_i,
  input  logic [4:0]                          shift_i,
  output logic                                fir_valid_o,
  output logic [DATA_SIZE-1:0]                fir_sample_o,
  input  logic                                fir_valid_i,
  input  logic signed [DATA_SIZE_FIR_OUT-1:0] fir_y_i,
  output logic                                dac_valid_o,
  output logic [NUM_CH*DATA_SIZE-1:0]         dac_data_o,
  output logic                                overrun_o,
  output logic [15:0]                         sat_cnt_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam int EXT_W = DATA_SIZE_FIR_OUT + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;

  logic [2:0]                  state;
  logic [CH_W-1:0]             ch;
  logic signed [DATA_SIZE-1:0] in_q  [NUM_CH];
  logic signed [DATA_SIZE-1:0] out_q [NUM_CH];
  logic [1:0]                  mode_q [NUM_CH];

  // Clipping: every bit above the output sign bit must agree with it.
  function automatic logic clip_chk(input logic signed [EXT_W-1:0] v);
    return !((&v[EXT_W-1:DATA_SIZE-1]) || !(|v[EXT_W-1:DATA_SIZE-1]));
  endfunction

  function automatic logic signed [DATA_SIZE-1:0] sat(input logic signed [EXT_W-1:0] v);
    if (!clip_chk(v))
      return v[DATA_SIZE-1:0];
    else if (v[EXT_W-1])
      return {1'b1, {(DATA_SIZE-1){1'b0}}};
    else
      return {1'b0, {(DATA_SIZE-1){1'b1}}};
  endfunction

  logic signed [DATA_SIZE_FIR_OUT-1:0] shifted;
  logic signed [EXT_W-1:0]             res_ext;
  logic                                res_clip;
  logic signed [DATA_SIZE-1:0]         res_sat;
  logic                                ch_done;

  // One extra bit so negating the most negative shifted value cannot wrap.
  always_comb begin
    shifted  = fir_y_i >>> shift_i;
    res_ext  = {shifted[DATA_SIZE_FIR_OUT-1], shifted};
    if (mode_q[ch][0])
      res_ext = -res_ext;
    res_clip = clip_chk(res_ext);
    res_sat  = sat(res_ext);
    ch_done  = ((state == SCAN) && !mode_q[ch][1]) ||
               ((state == WAIT) && fir_valid_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      ch           <= '0;
      fir_valid_o  <= 1'b0;
      fir_sample_o <= '0;
      dac_valid_o  <= 1'b0;
      dac_data_o   <= '0;
      overrun_o    <= 1'b0;
      sat_cnt_o    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        in_q[i]   <= '0;
        out_q[i]  <= '0;
        mode_q[i] <= '0;
      end
    end else begin
      fir_valid_o <= 1'b0;
      dac_valid_o <= 1'b0;
      if (adc_valid_i && (state != IDLE))
        overrun_o <= 1'b1;

      case (state)
        IDLE: begin
          if (adc_valid_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
              in_q[i]   <= adc_data_i[i*DATA_SIZE +: DATA_SIZE];
              mode_q[i] <= mode_i[2*i +: 2];
            end
            ch    <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          case (mode_q[ch])
            2'd0:    out_q[ch] <= '0;
            2'd1:    out_q[ch] <= in_q[ch];
            default: begin
              fir_valid_o  <= 1'b1;
              fir_sample_o <= in_q[ch];
              state        <= ISSUE;
            end
          endcase
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (fir_valid_i) begin
            out_q[ch] <= res_sat;
            if (res_clip && (sat_cnt_o != 16'hFFFF))
              sat_cnt_o <= sat_cnt_o + 16'd1;
          end
        end
        EMIT: begin
          for (int i = 0; i < NUM_CH; i++)
            dac_data_o[i*DATA_SIZE +: DATA_SIZE] <= out_q[i];
          dac_valid_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (ch_done) begin
        if (ch == LAST_CH) begin
          state <= EMIT;
        end else begin
          ch    <= ch + 1'b1;
          state <= SCAN;
        end
      end
    end
  end

endmodule

// File: tb/tb_student_audio_router.sv
// Directed bench for student_audio_router: a frame-level model predicts FIR issues and emitted frames,
// and a compare process checks every FIR strobe and every emitted frame against it.
module tb_student_audio_router;

  localparam int DS = 16;
  localparam int FO = 27;
  localparam int NC = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             adc_valid = 1'b0;
  logic [NC*DS-1:0] adc_data = '0;
  logic [2*NC-1:0]  mode = '0;
  logic [4:0]       shift = '0;
  logic             fir_valid_o;
  logic [DS-1:0]    fir_sample;
  logic             fir_valid_i = 1'b0;
  logic [FO-1:0]    fir_y = '0;
  logic             dac_valid;
  logic [NC*DS-1:0] dac_data;
  logic             overrun;
  logic [15:0]      sat_cnt;

  always #5 clk = ~clk;

  student_audio_router #(
    .DATA_SIZE(DS), .DATA_SIZE_FIR_OUT(FO), .NUM_CH(NC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .adc_valid_i(adc_valid), .adc_data_i(adc_data),
    .mode_i(mode), .shift_i(shift),
    .fir_valid_o(fir_valid_o), .fir_sample_o(fir_sample),
    .fir_valid_i(fir_valid_i), .fir_y_i(fir_y),
    .dac_valid_o(dac_valid), .dac_data_o(dac_data),
    .overrun_o(overrun), .sat_cnt_o(sat_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic [31:0] exp_dac_q[$];
  logic [15:0] exp_sat_q[$];
  logic [15:0] exp_fir_q[$];
  int          model_sat = 0;

  // Frame-level model: integer arithmetic on each channel's rule, ys[c] is the FIR answer for channel c.
  task automatic model_frame(input logic [31:0] din, input logic [3:0] modes,
                             input logic [26:0] y0, input logic [26:0] y1, input int sh);
    logic [31:0]        dout;
    logic [26:0]        ys [2];
    logic signed [26:0] yt;
    longint             v;
    logic [1:0]         m;
    ys[0] = y0;
    ys[1] = y1;
    dout  = '0;
    for (int c = 0; c < NC; c++) begin
      m = modes[2*c +: 2];
      if (m == 2'd0) begin
        dout[c*16 +: 16] = 16'h0000;
      end else if (m == 2'd1) begin
        dout[c*16 +: 16] = din[c*16 +: 16];
      end else begin
        exp_fir_q.push_back(din[c*16 +: 16]);
        yt = ys[c];
        v  = longint'(yt);
        v  = v >>> sh;
        if (m == 2'd3) v = -v;
        if (v > 32767) begin
          v = 32767;
          model_sat++;
        end else if (v < -32768) begin
          v = -32768;
          model_sat++;
        end
        dout[c*16 +: 16] = v[15:0];
      end
    end
    exp_dac_q.push_back(dout);
    exp_sat_q.push_back(16'(model_sat));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fir_valid_o) begin
        if (exp_fir_q.size() == 0) chk("fir_issue_expected", exp_fir_q.size(), 1);
        else chk("fir_sample", fir_sample, exp_fir_q.pop_front());
      end
      if (dac_valid) begin
        if (exp_dac_q.size() == 0) begin
          chk("dac_frame_expected", exp_dac_q.size(), 1);
        end else begin
          chk("dac_data", dac_data, exp_dac_q.pop_front());
          chk("dac_sat_cnt", sat_cnt, exp_sat_q.pop_front());
        end
      end
    end
  end

  task automatic send_frame(input logic [31:0] din, input logic [3:0] modes, input logic [4:0] sh);
    @(posedge clk); #1;
    adc_data  = din;
    mode      = modes;
    shift     = sh;
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  task automatic wait_dac(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (dac_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("dac_timeout", dac_valid, 1);
  endtask

  task automatic wait_fir();
    int seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fir_valid_o) begin
        seen = 1;
        break;
      end
    end
    if (seen == 0) chk("fir_timeout", fir_valid_o, 1);
  endtask

  task automatic respond(input logic [26:0] y, input int lat);
    repeat (lat) @(posedge clk);
    #1;
    fir_valid_i = 1'b1;
    fir_y       = y;
    @(posedge clk); #1;
    fir_valid_i = 1'b0;
    fir_y       = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dac_valid", dac_valid, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_fir_valid", fir_valid_o, 0);
    chk("rst_fir_sample", fir_sample, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;

    // ch0 bypass, ch1 mute
    model_frame(32'h7FFF_1234, 4'b0001, 27'h0, 27'h0, 0);
    send_frame(32'h7FFF_1234, 4'b0001, 5'd0);
    wait_dac(lat);
    chk("t1_latency", lat, 4);
    chk("t1_data", dac_data, 32'h0000_1234);
    repeat (3) @(negedge clk);
    chk("t1_hold", dac_data, 32'h0000_1234);

    // ch0 FIR shift 3, ch1 bypass
    model_frame(32'hBEEF_1111, 4'b0110, 27'h0000800, 27'h0, 3);
    send_frame(32'hBEEF_1111, 4'b0110, 5'd3);
    wait_fir();
    respond(27'h0000800, 5);
    wait_dac(lat);
    chk("t2_data", dac_data, 32'hBEEF_0100);
    chk("t2_sat", sat_cnt, 0);

    // positive and negative full-scale FIR results
    model_frame(32'h2222_3333, 4'b1010, 27'h3FFFFFF, 27'h4000000, 0);
    send_frame(32'h2222_3333, 4'b1010, 5'd0);
    wait_fir();
    respond(27'h3FFFFFF, 3);
    chk("t3_sat_first", sat_cnt, 1);
    wait_fir();
    respond(27'h4000000, 3);
    wait_dac(lat);
    chk("t3_data", dac_data, 32'h8000_7FFF);
    chk("t3_sat", sat_cnt, 2);

    // invert: -0x8000 clips, -5 becomes +5
    model_frame(32'h0101_0202, 4'b1111, 27'h7FF8000, 27'h7FFFFFB, 0);
    send_frame(32'h0101_0202, 4'b1111, 5'd0);
    wait_fir();
    respond(27'h7FF8000, 2);
    wait_fir();
    respond(27'h7FFFFFB, 2);
    wait_dac(lat);
    chk("t4_data", dac_data, 32'h0005_7FFF);
    chk("t4_sat", sat_cnt, 3);

    // sign-preserving shift, with and without invert
    model_frame(32'h0303_0404, 4'b1110, 27'h7FFFF00, 27'h0000123, 4);
    send_frame(32'h0303_0404, 4'b1110, 5'd4);
    wait_fir();
    respond(27'h7FFFF00, 4);
    wait_fir();
    respond(27'h0000123, 1);
    wait_dac(lat);
    chk("t4b_data", dac_data, 32'hFFEE_FFF0);

    // frame arriving during WAIT is dropped; mode change after latch is ignored
    model_frame(32'h4444_5555, 4'b0110, 27'h0000200, 27'h0, 1);
    send_frame(32'h4444_5555, 4'b0110, 5'd1);
    mode = 4'b0000;
    chk("t5_overrun_before", overrun, 0);
    wait_fir();
    @(posedge clk); #1;
    adc_data  = 32'hDEAD_BEEF;
    mode      = 4'b0101;
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    chk("t5_overrun", overrun, 1);
    respond(27'h0000200, 5);
    wait_dac(lat);
    chk("t5_data", dac_data, 32'h4444_0100);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (dac_valid) cnt++;
    end
    chk("t5_no_dropped_frame", cnt, 0);

    // reset while waiting on the FIR
    model_frame(32'h6666_7777, 4'b0010, 27'h0000100, 27'h0, 0);
    send_frame(32'h6666_7777, 4'b0010, 5'd0);
    wait_fir();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_dac_q.delete();
    exp_sat_q.delete();
    exp_fir_q.delete();
    model_sat = 0;
    #1;
    chk("t6_dac_valid", dac_valid, 0);
    chk("t6_dac_data", dac_data, 0);
    chk("t6_fir_valid", fir_valid_o, 0);
    chk("t6_fir_sample", fir_sample, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_sat_cnt", sat_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fir_valid_i = 1'b1;
    fir_y       = 27'h3FFFFFF;
    @(posedge clk); #1;
    fir_valid_i = 1'b0;
    fir_y       = '0;
    repeat (2) @(negedge clk);
    chk("t6_stray_sat", sat_cnt, 0);
    chk("t6_stray_dac", dac_valid, 0);
    model_frame(32'hA5A5_5A5A, 4'b0101, 27'h0, 27'h0, 0);
    send_frame(32'hA5A5_5A5A, 4'b0101, 5'd0);
    wait_dac(lat);
    chk("t6_latency", lat, 4);
    chk("t6_data", dac_data, 32'hA5A5_5A5A);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
